// File: rtl/bp_pkg.sv
// Shared constants for the branch predictor: 2-bit counter encodings and
// the values used on reset/invalidate and on fresh allocation.
package bp_pkg;

    localparam logic [1:0] CTR_SNT   = 2'b00;
    localparam logic [1:0] CTR_WNT   = 2'b01;
    localparam logic [1:0] CTR_WT    = 2'b10;
    localparam logic [1:0] CTR_ST    = 2'b11;

    localparam logic [1:0] CTR_RESET = CTR_WNT;
    localparam logic [1:0] CTR_ALLOC = CTR_WT;

endpackage

// File: rtl/btb_predictor_sat_ctr2.sv
// 2-bit saturating counter next-state: one instance per update port,
// shared by all table entries.
module sat_ctr2
    import bp_pkg::*;
(
    input  logic [1:0] cur_i,
    input  logic       taken_i,
    output logic [1:0] next_o
);

    always_comb begin
        next_o = cur_i;
        if (taken_i) begin
            if (cur_i != CTR_ST) begin
                next_o = cur_i + 2'd1;
            end
        end else begin
            if (cur_i != CTR_SNT) begin
                next_o = cur_i - 2'd1;
            end
        end
    end

endmodule

// File: rtl/btb_predictor.sv
// Direct-mapped BTB with 2-bit counters: combinational IF-side lookup,
// EX/MEM-side training, mispredict redirect and saturating statistics.
module btb_predictor
    import bp_pkg::*;
#(
    parameter int unsigned IDX_W = 4,
    parameter int unsigned TAG_W = 32 - IDX_W - 2,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btb_clr,
    input  logic [31:0]      if_pc,
    output logic             pred_hit,
    output logic             pred_taken,
    output logic [31:0]      pred_target,
    output logic [31:0]      hit_choice_out,
    input  logic             upd_valid,
    input  logic [31:0]      upd_pc,
    input  logic             upd_taken,
    input  logic [31:0]      upd_target,
    input  logic             upd_pred_taken,
    input  logic [31:0]      upd_pred_target,
    output logic             mispredict,
    output logic [31:0]      redirect_addr,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mp_count
);

    localparam int unsigned ENTRIES = 1 << IDX_W;

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [TAG_W-1:0]   tag_d    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic [31:0]        target_d [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];
    logic [1:0]         ctr_d    [ENTRIES];
    logic [CNT_W-1:0]   br_count_q, br_count_d;
    logic [CNT_W-1:0]   mp_count_q, mp_count_d;

    logic [IDX_W-1:0]   lidx, uidx;
    logic [TAG_W-1:0]   ltag, utag;
    logic               upd_hit;
    logic [1:0]         ctr_upd;
    logic               unused_pc_lsbs;

    assign unused_pc_lsbs = ^{if_pc[1:0], upd_pc[1:0]};

    always_comb begin
        lidx = if_pc[IDX_W+1:2];
        ltag = if_pc[31:IDX_W+2];
        uidx = upd_pc[IDX_W+1:2];
        utag = upd_pc[31:IDX_W+2];
    end

    // Lookup reads the registered table only, so a same-cycle update is not bypassed.
    always_comb begin
        pred_hit       = valid_q[lidx] && (tag_q[lidx] == ltag);
        pred_taken     = pred_hit && ctr_q[lidx][1];
        pred_target    = target_q[lidx];
        hit_choice_out = pred_taken ? pred_target : (if_pc + 32'd4);
    end

    always_comb begin
        mispredict    = upd_valid && ((upd_taken != upd_pred_taken) ||
                                      (upd_taken && (upd_target != upd_pred_target)));
        redirect_addr = (upd_valid && upd_taken) ? upd_target : (upd_pc + 32'd4);
    end

    sat_ctr2 u_sat_ctr2 (
        .cur_i   (ctr_q[uidx]),
        .taken_i (upd_taken),
        .next_o  (ctr_upd)
    );

    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        upd_hit  = valid_q[uidx] && (tag_q[uidx] == utag);
        // Invalidate takes priority over a concurrent training update.
        if (btb_clr) begin
            valid_d = '0;
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                ctr_d[i] = CTR_RESET;
            end
        end else if (upd_valid) begin
            if (upd_hit) begin
                ctr_d[uidx] = ctr_upd;
                if (upd_taken) begin
                    target_d[uidx] = upd_target;
                end
            end else if (upd_taken) begin
                valid_d[uidx]  = 1'b1;
                tag_d[uidx]    = utag;
                target_d[uidx] = upd_target;
                ctr_d[uidx]    = CTR_ALLOC;
            end
        end
    end

    always_comb begin
        br_count_d = br_count_q;
        mp_count_d = mp_count_q;
        if (upd_valid && (br_count_q != '1)) begin
            br_count_d = br_count_q + CNT_W'(1);
        end
        if (mispredict && (mp_count_q != '1)) begin
            mp_count_d = mp_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= '0;
            br_count_q <= '0;
            mp_count_q <= '0;
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_RESET;
            end
        end else begin
            valid_q    <= valid_d;
            tag_q      <= tag_d;
            target_q   <= target_d;
            ctr_q      <= ctr_d;
            br_count_q <= br_count_d;
            mp_count_q <= mp_count_d;
        end
    end

    assign br_count = br_count_q;
    assign mp_count = mp_count_q;

endmodule
